// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
//   Shared definitions for the iterative multiply/divide sequencer:
//   operation codes, FSM state encoding, datapath mode and a magnitude helper.
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

  localparam int XLEN = 32;

  // Operation codes presented on op together with a start strobe.
  typedef enum logic [2:0] {
    MD_OP_MULT  = 3'd0,
    MD_OP_MULTU = 3'd1,
    MD_OP_DIV   = 3'd2,
    MD_OP_DIVU  = 3'd3,
    MD_OP_MTHI  = 3'd4,
    MD_OP_MTLO  = 3'd5,
    MD_OP_NOP   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_CALC = 2'd1,
    MD_ST_SIGN = 2'd2
  } md_state_e;

  // Selects what the shared iteration cell does this cycle.
  typedef enum logic {
    MD_MODE_MUL = 1'b0,
    MD_MODE_DIV = 1'b1
  } md_mode_e;

  // Magnitude of a two's-complement word, read back as unsigned.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_if
//   Execute-stage <-> mul/div sequencer connection.
//   master (pipeline): drives start, op, a, b; observes busy, done, hi, lo.
//   slave  (muldiv_ctrl): the reverse.
// -----------------------------------------------------------------------------
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic            start;  // request strobe, sampled only while idle
  md_op_e          op;     // operation code
  logic [XLEN-1:0] a;      // rs: multiplicand / dividend / MTHI-MTLO data
  logic [XLEN-1:0] b;      // rt: multiplier / divisor
  logic            busy;   // mul/div in flight
  logic            done;   // one-cycle pulse after hi/lo take a result
  logic [XLEN-1:0] hi;     // architectural HI
  logic [XLEN-1:0] lo;     // architectural LO

  modport master (output start, op, a, b, input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//   Combinational single iteration of the shared 33-bit add/sub datapath.
//   mode=MUL : {acc, shreg} is the 64-bit partial product; add operand when
//              shreg[0] is set, then shift the whole pair right by one.
//   mode=DIV : {acc, shreg} is {remainder, quotient}; shift left by one,
//              trial-subtract operand, keep the difference if non-negative
//              and shift the success bit into the quotient.
//   Ports: mode, acc, shreg, operand in; acc_next, shreg_next out.
// -----------------------------------------------------------------------------
module muldiv_step
  import muldiv_ctrl_pkg::*;
(
  input  md_mode_e        mode,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] shreg,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] shreg_next
);

  logic [XLEN:0] lhs;
  logic [XLEN:0] rhs;
  logic [XLEN:0] res;
  logic          cin;

  always_comb begin
    // NOTE: every variable in a combinational block gets a value on every
    // path (here, up front) so no latch is inferred.
    lhs        = {1'b0, acc};
    rhs        = '0;
    cin        = 1'b0;
    acc_next   = acc;
    shreg_next = shreg;

    if (mode == MD_MODE_MUL) begin
      rhs = shreg[0] ? {1'b0, operand} : '0;
    end else begin
      // Subtract as add of the inverted divisor plus carry-in.
      lhs = {acc, shreg[XLEN-1]};
      rhs = ~{1'b0, operand};
      cin = 1'b1;
    end

    res = lhs + rhs + {{XLEN{1'b0}}, cin};

    if (mode == MD_MODE_MUL) begin
      acc_next   = res[XLEN:1];
      shreg_next = {res[0], shreg[XLEN-1:1]};
    end else begin
      // The remainder is always below the divisor, so the shifted value is
      // below twice the divisor and bit XLEN of the difference is a true
      // borrow flag.
      acc_next   = res[XLEN] ? lhs[XLEN-1:0] : res[XLEN-1:0];
      shreg_next = {shreg[XLEN-2:0], ~res[XLEN]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   Iterative MULT/MULTU/DIV/DIVU sequencer that also owns HI/LO and executes
//   MTHI/MTLO. One iteration per cycle through muldiv_step; signed operations
//   run on magnitudes and are sign-corrected in a final SIGN cycle.
//   Latency: start edge N, CALC for ITER cycles, SIGN writes hi/lo at edge
//   N+ITER+1, done pulses in the following cycle.
//   Ports: clk, rst (synchronous, active high), bus (muldiv_ctrl_if.slave).
// -----------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int ITER = XLEN  // iterations per mul/div; must equal XLEN
)(
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(ITER + 1);

  md_state_e       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [XLEN-1:0] acc_q,     acc_d;      // product high half / remainder
  logic [XLEN-1:0] shreg_q,   shreg_d;    // multiplier-product low / quotient
  logic [XLEN-1:0] opnd_q,    opnd_d;     // multiplicand / divisor magnitude
  md_mode_e        mode_q,    mode_d;
  logic            sgn_q,     sgn_d;      // signed operation
  logic            res_neg_q, res_neg_d;  // product / quotient needs negation
  logic            rem_neg_q, rem_neg_d;  // remainder needs negation
  logic [XLEN-1:0] hi_q,      hi_d;
  logic [XLEN-1:0] lo_q,      lo_d;
  logic            done_q,    done_d;

  logic [XLEN-1:0]   step_acc;
  logic [XLEN-1:0]   step_shreg;
  logic [2*XLEN-1:0] prod;
  logic              op_signed;
  logic              op_div;

  assign prod      = {acc_q, shreg_q};
  assign op_signed = (bus.op == MD_OP_MULT) || (bus.op == MD_OP_DIV);
  assign op_div    = (bus.op == MD_OP_DIV)  || (bus.op == MD_OP_DIVU);

  muldiv_step u_step (
    .mode       (mode_q),
    .acc        (acc_q),
    .shreg      (shreg_q),
    .operand    (opnd_q),
    .acc_next   (step_acc),
    .shreg_next (step_shreg)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    shreg_d   = shreg_q;
    opnd_d    = opnd_q;
    mode_d    = mode_q;
    sgn_d     = sgn_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      MD_ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
              mode_d    = op_div ? MD_MODE_DIV : MD_MODE_MUL;
              sgn_d     = op_signed;
              shreg_d   = op_signed ? abs_mag(bus.a) : bus.a;
              opnd_d    = op_signed ? abs_mag(bus.b) : bus.b;
              res_neg_d = bus.a[XLEN-1] ^ bus.b[XLEN-1];
              rem_neg_d = bus.a[XLEN-1];
              acc_d     = '0;
              cnt_d     = '0;
              state_d   = MD_ST_CALC;
            end
            MD_OP_MTHI: hi_d = bus.a;
            MD_OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end

      MD_ST_CALC: begin
        acc_d   = step_acc;
        shreg_d = step_shreg;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) state_d = MD_ST_SIGN;
      end

      MD_ST_SIGN: begin
        if (mode_q == MD_MODE_MUL) begin
          {hi_d, lo_d} = (sgn_q && res_neg_q) ? -prod : prod;
        end else begin
          lo_d = (sgn_q && res_neg_q) ? -shreg_q : shreg_q;
          hi_d = (sgn_q && rem_neg_q) ? -acc_q   : acc_q;
        end
        done_d  = 1'b1;
        state_d = MD_ST_IDLE;
      end

      default: state_d = MD_ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      shreg_q   <= '0;
      opnd_q    <= '0;
      mode_q    <= MD_MODE_MUL;
      sgn_q     <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      shreg_q   <= shreg_d;
      opnd_q    <= opnd_d;
      mode_q    <= mode_d;
      sgn_q     <= sgn_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != MD_ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//   Self-checking bench for muldiv_ctrl: directed corner cases plus a random
//   sweep compared against a 64-bit arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  muldiv_ctrl_if md_if ();

  muldiv_ctrl #(.ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input md_op_e op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    case (op)
      MD_OP_MULTU: return {32'b0, a} * {32'b0, b};
      MD_OP_MULT:  return sa * sb;
      MD_OP_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      MD_OP_DIV: begin
        // Divide by zero: quotient magnitude all ones, remainder |a|, then
        // the usual sign fixups (remainder returns to a).
        if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return 64'b0;
    endcase
  endfunction

  function automatic md_op_e junk_op();
    int unsigned v;
    v = $urandom_range(0, 6);
    return (v == 6) ? MD_OP_NOP : md_op_e'(3'(v));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'(int'($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  // Issue one mul/div, throw random start requests at it while busy, and
  // check result, latency, busy length, hi/lo hold and the done pulse width.
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          edges;
    int          busy_cnt;
    logic        held;
    logic        seen;
    old_hi   = md_if.hi;
    old_lo   = md_if.lo;
    held     = 1'b1;
    seen     = 1'b0;
    edges    = 0;
    @(negedge clk);
    md_if.start = 1'b1;
    md_if.op    = op;
    md_if.a     = a;
    md_if.b     = b;
    @(posedge clk); #1;
    busy_cnt = md_if.busy ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      md_if.start = 1'($urandom_range(0, 1));
      md_if.op    = junk_op();
      md_if.a     = $urandom;
      md_if.b     = $urandom;
      @(posedge clk); #1;
      edges++;
      if (md_if.done) begin
        seen = 1'b1;
        break;
      end
      if (md_if.busy) busy_cnt++;
      if (md_if.hi !== old_hi || md_if.lo !== old_lo) held = 1'b0;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " hilo"}, {md_if.hi, md_if.lo}, exp);
    check({tag, " latency"}, 64'(edges), 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " hold"}, 64'(held), 64'd1);
    @(negedge clk);
    md_if.start = 1'b0;
    @(posedge clk); #1;
    check({tag, " done_pulse"}, {62'b0, md_if.done, md_if.busy}, 64'd0);
  endtask

  initial begin
    bit saw_done;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    md_if.start = 1'b0;
    md_if.op    = MD_OP_NOP;
    md_if.a     = '0;
    md_if.b     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(md_if.busy), 64'd0);
    check("rst done", 64'(md_if.done), 64'd0);
    check("rst hi", 64'(md_if.hi), 64'd0);
    check("rst lo", 64'(md_if.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // MTHI then MTLO on consecutive cycles
    md_if.start = 1'b1;
    md_if.op    = MD_OP_MTHI;
    md_if.a     = 32'h1234_5678;
    @(posedge clk); #1;
    check("mthi hi", 64'(md_if.hi), 64'h1234_5678);
    check("mthi busy_done", {62'b0, md_if.busy, md_if.done}, 64'd0);
    @(negedge clk);
    md_if.op = MD_OP_MTLO;
    md_if.a  = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    check("mtlo lo", 64'(md_if.lo), 64'h9ABC_DEF0);
    check("mtlo hi", 64'(md_if.hi), 64'h1234_5678);
    check("mtlo busy_done", {62'b0, md_if.busy, md_if.done}, 64'd0);

    // NOP code with start leaves everything alone
    @(negedge clk);
    md_if.op = MD_OP_NOP;
    md_if.a  = 32'hDEAD;
    @(posedge clk); #1;
    check("nop hilo", {md_if.hi, md_if.lo}, 64'h1234_5678_9ABC_DEF0);
    check("nop busy", 64'(md_if.busy), 64'd0);
    @(negedge clk);
    md_if.start = 1'b0;

    // Directed corner cases with hand-derived results
    run_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
    run_op(MD_OP_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, "mult_neg");
    run_op(MD_OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
    run_op(MD_OP_DIVU,  32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, "divu_zero");
    run_op(MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf");

    // Reset in the middle of a divide: no result, no done pulse
    @(negedge clk);
    md_if.start = 1'b1;
    md_if.op    = MD_OP_DIVU;
    md_if.a     = 32'd1000;
    md_if.b     = 32'd3;
    @(posedge clk);
    @(negedge clk);
    md_if.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst busy", 64'(md_if.busy), 64'd0);
    check("midrst done", 64'(md_if.done), 64'd0);
    check("midrst hilo", {md_if.hi, md_if.lo}, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (md_if.done || md_if.busy) saw_done = 1'b1;
    end
    check("midrst quiet", 64'(saw_done), 64'd0);
    run_op(MD_OP_MULTU, 32'd6, 32'd7, 64'd42, "multu_after_rst");

    // Randomized sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      md_op_e      op;
      logic [31:0] a;
      logic [31:0] b;
      op = md_op_e'(3'($urandom_range(0, 3)));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, model(op, a, b), $sformatf("rnd%0d op%0d a=%h b=%h", i, op, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the MIPS core. Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage. The pipeline control stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.
- Uses one shared 33-bit add/sub datapath per iteration: shift-add for multiply, restoring subtract for divide.

Parameters:
- ITER, 32, number of arithmetic iterations per mul/div; must equal operand width.

Ports:
- clk    input   1   system clock; all state updates on the rising edge
- rst    input   1   synchronous, active-high reset
- start  input   1   request strobe; sampled only in IDLE
- op     input   3   operation code, MD_OP_* values
- a      input   32  rs operand: multiplicand/dividend, or MTHI/MTLO data
- b      input   32  rt operand: multiplier/divisor
- busy   output  1   high while a mul/div is in flight
- done   output  1   one-cycle pulse in the cycle after hi/lo receive a mul/div result
- hi     output  32  HI register
- lo     output  32  LO register

Behaviour:
- Reset (clk edge with rst=1, at any time): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset aborts an in-flight operation; the partial result is discarded.
- States: IDLE, CALC, SIGN.
- IDLE with start=1 and op ∈ {MULT, MULTU, DIV, DIVU} (edge N):
  - latch |a| and |b| (signed ops) or a and b (unsigned ops);
  - latch result sign (a[31]^b[31]) and remainder sign (a[31]);
  - clear the accumulator; counter=0; go to CALC.
- IDLE with start=1 and op=MTHI: hi<=a at that edge. op=MTLO: lo<=a. No busy, no done. Any other op code is a NOP.
- CALC: one iteration per cycle; counter increments each cycle. After ITER iterations (edge N+32), go to SIGN.
  - Multiply: 64-bit product {acc, mplier} is shifted right, with a conditional add of the multiplicand when the LSB is 1.
  - Divide: restoring divide. Shift {rem, quot} left, trial-subtract the divisor in 33 bits, commit if non-negative, set quotient bit.
- SIGN (edge N+33):
  - signed multiply: if result sign=1, two's-complement negate the 64-bit product;
  - signed divide: negate the quotient if the result sign is set; negate the remainder if the remainder sign is set;
  - write {hi,lo}; go to IDLE.
- done=1 during the cycle after edge N+33 only; otherwise 0.
- busy=1 whenever state≠IDLE, i.e. from after edge N through edge N+33 (33 cycles). Total latency from start edge to done: 34 cycles.
- start while busy is ignored; op/a/b are don't-care during CALC/SIGN.
- hi/lo hold their old values until the SIGN write. MFHI issued during busy is the pipeline's responsibility to stall.
- Division by zero: no trap, same latency.
  - DIVU: lo=32'hFFFFFFFF, hi=a.
  - DIV: result follows the same sign fixup on those magnitudes.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no exception).
- Negation of 0x80000000 magnitude is handled by treating magnitudes as 32-bit unsigned.

Decomposition:
- Shared header `muldiv_defs.v`:
  - MD_OP_MULT=3'd0, MD_OP_MULTU=3'd1, MD_OP_DIV=3'd2, MD_OP_DIVU=3'd3, MD_OP_MTHI=3'd4, MD_OP_MTLO=3'd5, MD_OP_NOP=3'd7;
  - state encodings MD_ST_IDLE/CALC/SIGN.
- One sub-module: muldiv_step, the combinational single-iteration shift/add-sub cell. It takes mode, acc and operand, and returns the next {acc, shreg}.
- The FSM, counter and HI/LO registers stay in muldiv_ctrl.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after 34 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD(-3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 → lo=0xFFFFFFFF, hi=0x00000064, done at cycle 34; DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles → hi/lo updated next edge, busy and done stay 0; second start during busy (MTHI a=0xDEAD) → hi unchanged until and after done.
- Start DIVU 1000/3, assert rst at cycle 10 for one edge → busy=0, done=0, hi=lo=0, never a done pulse; a new MULTU 6×7 afterwards gives lo=42, hi=0.
- Randomized sweep of 1000 ops checked against a behavioural 64-bit model → zero mismatches; print an error count at the end.
